parse_match_ctrl: RTL and testbench

Sequencer for the serial-stream parse path. Frames an MSB-first bit stream into 128-bit words, then checks each framed word against a bank of prestored constant keys, one key per cycle. It reports the match result and the matching key index to downstream crypto logic with a one-cycle done strobe. Input is back-pressured while a comparison is in flight.

---
 rtl/parse_match_ctrl.sv | 124 ++++++++++++
 tb/tb_parse_match_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/parse_match_ctrl.sv
// Purpose: frames an MSB-first serial stream into DATA_W-bit words and matches each word against a constant key bank.
// Latency: done rises k+2 cycles after the last frame bit for a hit on key k, NUM_KEYS+1 cycles for a miss.
// Backpressure: in_ready is low from the cycle after the last frame bit through the done cycle.
module parse_match_ctrl #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    parameter logic [NUM_KEYS*DATA_W-1:0] KEYS = {
        128'h0123456789ABCDEF_FEDCBA9876543210,
        {128{1'b1}},
        128'hDEADBEEF_CAFEF00D_0BADC0DE_8BADF00D,
        128'h0
    }
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_data,
    input  logic              end_of_sequence,
    output logic              in_ready,
    output logic              done,
    output logic              match,
    output logic [IDX_W-1:0]  match_idx,
    output logic [DATA_W-1:0] frame_out,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_KEY = IDX_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        COMPARE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  key_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] cur_key;

    // Key 0 sits in the MSBs of KEYS, so key k is counted down from the top.
    always_comb begin
        cur_key = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_idx == IDX_W'(k)) begin
                cur_key = KEYS[(NUM_KEYS-1-k)*DATA_W +: DATA_W];
            end
        end
    end

    // Ready only while framing; reset forces it low so no beat is lost to a reset edge.
    always_comb begin
        in_ready = (state == SHIFT) && !rst;
    end

    // Framing / sequential key search / result reporting FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            key_idx   <= '0;
            shreg     <= '0;
            done      <= 1'b0;
            match     <= 1'b0;
            match_idx <= '0;
            frame_out <= '0;
            frame_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                SHIFT: begin
                    if (in_valid) begin
                        shreg <= {shreg[DATA_W-2:0], in_data};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (end_of_sequence) begin
                                state   <= COMPARE;
                                key_idx <= '0;
                            end else begin
                                // Frame overran DATA_W bits without a terminator.
                                frame_err <= 1'b1;
                            end
                        end else if (end_of_sequence) begin
                            // Terminator arrived before the frame was full.
                            bit_cnt   <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    if (shreg == cur_key) begin
                        // First hit wins, giving lowest-index priority on duplicates.
                        match     <= 1'b1;
                        match_idx <= key_idx;
                        frame_out <= shreg;
                        done      <= 1'b1;
                        state     <= REPORT;
                    end else if (key_idx == LAST_KEY) begin
                        match     <= 1'b0;
                        match_idx <= '0;
                        frame_out <= shreg;
                        done      <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        key_idx <= key_idx + 1'b1;
                    end
                end
                REPORT: begin
                    state <= SHIFT;
                end
                default: begin
                    state <= SHIFT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parse_match_ctrl.sv
// Purpose: directed plus randomized checks of parse_match_ctrl against a key-list reference model.
// Latency: expected done cycle is derived from the index of the first matching key.
// Backpressure: in_ready is checked low for every stall cycle and high when framing.
module tb_parse_match_ctrl;

    localparam int DW = 128;
    localparam int NK = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_data = 1'b0;
    logic          eos = 1'b0;
    logic          in_ready;
    logic          done;
    logic          match;
    logic [IW-1:0] match_idx;
    logic [DW-1:0] frame_out;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] keys [NK];

    parse_match_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .end_of_sequence (eos),
        .in_ready        (in_ready),
        .done            (done),
        .match           (match),
        .match_idx       (match_idx),
        .frame_out       (frame_out),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: index of the first key equal to the word, -1 if none.
    function automatic int ref_idx(input logic [DW-1:0] w);
        for (int i = 0; i < NK; i++) begin
            if (w == keys[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams the top nbits of w MSB first; optional random gaps; hold keeps in_valid up afterwards.
    task automatic send_bits(input logic [DW-1:0] w, input int nbits, input bit eos_last,
                             input int gap_pct, input bit hold);
        for (int i = 0; i < nbits; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 1'($urandom);
                eos      = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = w[DW-1-i];
            eos      = eos_last && (i == nbits - 1);
            @(negedge clk);
            chk("shift_ready", DW'(in_ready), DW'(1));
            tick();
        end
        eos = 1'b0;
        if (hold) begin
            in_data = 1'($urandom);
            eos     = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Walks the cycles after the last accepted bit and checks stall, done timing and results.
    task automatic expect_result(input string tag, input logic [DW-1:0] w);
        int k;
        int lat;
        k   = ref_idx(w);
        lat = (k >= 0) ? 2 + k : 1 + NK;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n < lat) begin
                chk({tag, "_stall_ready"}, DW'(in_ready), DW'(0));
                chk({tag, "_early_done"}, DW'(done), DW'(0));
            end else if (n == lat) begin
                chk({tag, "_done"}, DW'(done), DW'(1));
                chk({tag, "_report_ready"}, DW'(in_ready), DW'(0));
                chk({tag, "_match"}, DW'(match), DW'(k >= 0));
                chk({tag, "_match_idx"}, DW'(match_idx), DW'((k >= 0) ? k : 0));
                chk({tag, "_frame_out"}, frame_out, w);
                in_valid = 1'b0;
                eos      = 1'b0;
            end else begin
                chk({tag, "_done_pulse"}, DW'(done), DW'(0));
                chk({tag, "_ready_again"}, DW'(in_ready), DW'(1));
                chk({tag, "_no_err"}, DW'(frame_err), DW'(0));
            end
            tick();
        end
    endtask

    // After a malformed frame: one-cycle frame_err, no done, still ready.
    task automatic expect_err(input string tag);
        @(negedge clk);
        chk({tag, "_err"}, DW'(frame_err), DW'(1));
        chk({tag, "_no_done"}, DW'(done), DW'(0));
        chk({tag, "_ready"}, DW'(in_ready), DW'(1));
        tick();
        @(negedge clk);
        chk({tag, "_err_pulse"}, DW'(frame_err), DW'(0));
        tick();
    endtask

    initial begin
        logic [DW-1:0] w;
        int            sel;

        keys[0] = 128'h0123456789ABCDEF_FEDCBA9876543210;
        keys[1] = {DW{1'b1}};
        keys[2] = 128'hDEADBEEF_CAFEF00D_0BADC0DE_8BADF00D;
        keys[3] = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", DW'(in_ready), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_match", DW'(match), DW'(0));
        chk("rst_idx", DW'(match_idx), DW'(0));
        chk("rst_frame", frame_out, '0);
        chk("rst_err", DW'(frame_err), DW'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", DW'(in_ready), DW'(1));
        tick();

        // Key 2 match
        send_bits(keys[2], DW, 1'b1, 0, 1'b0);
        expect_result("key2", keys[2]);

        // No match
        w = {64'h5555555555555555, 64'h5555555555555555};
        send_bits(w, DW, 1'b1, 0, 1'b0);
        expect_result("nomatch", w);

        // Short frame then key 0
        w = {4{32'($urandom)}};
        send_bits(w, 100, 1'b1, 0, 1'b0);
        expect_err("short");
        send_bits(keys[0], DW, 1'b1, 0, 1'b0);
        expect_result("key0", keys[0]);

        // Long frame then all zeros
        w = {4{32'($urandom)}};
        send_bits(w, DW, 1'b0, 0, 1'b0);
        expect_err("long");
        send_bits(keys[3], DW, 1'b1, 0, 1'b0);
        expect_result("zeros", keys[3]);

        // Key 1 with gaps, valid held through the stall, then hold check
        send_bits(keys[1], DW, 1'b1, 30, 1'b1);
        expect_result("key1_hold", keys[1]);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("stable_match", DW'(match), DW'(1));
            chk("stable_idx", DW'(match_idx), DW'(1));
            chk("stable_frame", frame_out, keys[1]);
            chk("stable_done", DW'(done), DW'(0));
            tick();
        end

        // Reset during COMPARE
        send_bits(keys[2], DW, 1'b1, 0, 1'b0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", DW'(in_ready), DW'(0));
        tick();
        @(negedge clk);
        chk("midrst_done", DW'(done), DW'(0));
        chk("midrst_match", DW'(match), DW'(0));
        chk("midrst_idx", DW'(match_idx), DW'(0));
        chk("midrst_frame", frame_out, '0);
        chk("midrst_err", DW'(frame_err), DW'(0));
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("after_rst_ready", DW'(in_ready), DW'(1));
            chk("after_rst_no_done", DW'(done), DW'(0));
            tick();
        end
        send_bits(keys[0], DW, 1'b1, 0, 1'b0);
        expect_result("key0_after_rst", keys[0]);

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            sel = int'($urandom_range(5));
            w   = (sel < NK) ? keys[sel] : {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            send_bits(w, DW, 1'b1, int'($urandom_range(40)), 1'($urandom));
            expect_result("rand", w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
